hack_data_memory: RTL and testbench

HACK_DATA_MEMORY -- requirements
Module: hack_data_memory

---
 rtl/hack_data_memory.sv | 177 +++++++++++++++++
 tb/tb_hack_data_memory.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_data_memory.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// HackDataMemory (module hack_data_memory)
//
// Data-side memory map for a Hack CPU. General RAM, an optional screen
// buffer with a registered scan port, and a keyboard keycode FIFO all share
// one CPU data port.
//
//   addrM[14:0]       region
//   0x0000 - 0x3FFF   general RAM (first RAM_WORDS words populated)
//   0x4000 - 0x5FFF   screen buffer (only when HACK_MEM_SCREEN_EN is defined)
//   0x6000            keyboard FIFO head (read) / pop strobe (write)
//   0x6001 - 0x7FFF   unmapped, reads 0, writes dropped
//
// Build option:
//   HACK_MEM_SCREEN_EN  defined   -> 8192-word screen and scan port present
//                       undefined -> screen reads 0, scr_data held at 0
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-low
//   addrM      in   16  CPU data address (bit 15 ignored)
//   outM       in   16  CPU write data
//   writeM     in   1   CPU write strobe
//   inM        out  16  combinational read data
//   key_code   in   16  keycode from keyboard source
//   key_valid  in   1   key_code valid
//   key_ready  out  1   FIFO has room for a keycode
//   kbd_count  out  5   FIFO occupancy
//   scr_addr   in   13  display scan word address
//   scr_data   out  16  registered display scan data
// ----------------------------------------------------------------------------
module hack_data_memory #(
   parameter int KBD_DEPTH = 4,
   parameter int RAM_WORDS = 16384
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addrM,
   input  logic [15:0] outM,
   input  logic        writeM,
   output logic [15:0] inM,
   input  logic [15:0] key_code,
   input  logic        key_valid,
   output logic        key_ready,
   output logic [4:0]  kbd_count,
   input  logic [12:0] scr_addr,
   output logic [15:0] scr_data
);

   localparam int          PTR_W     = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
   localparam int          RAM_AW    = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_LIMIT = 32'(RAM_WORDS);

   logic [14:0] addr;
   logic        ramSel;
   logic        scrSel;
   logic        kbdSel;
   logic [15:0] scrRead;
   logic [15:0] kbdHead;
   logic        push;
   logic        pop;
   logic        unusedAddrTop;

   logic [15:0]      ramMem [RAM_WORDS];
   logic [15:0]      kbdMem [KBD_DEPTH];
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [4:0]       count_q, count_d;

   // Only 15 address bits are decoded; the top bit aliases the map.
   assign addr          = addrM[14:0];
   assign unusedAddrTop = addrM[15];

   // Region decode. RAM may be smaller than its 16K window, in which case
   // the unpopulated tail of the window behaves like unmapped space.
   assign ramSel = (addr[14] == 1'b0) && ({18'd0, addr[13:0]} < RAM_LIMIT);
   assign scrSel = (addr[14:13] == 2'b10);
   assign kbdSel = (addr == 15'h6000);

   // General RAM is deliberately not reset so program data survives a reset
   // pulse; writes are simply blocked while reset is held.
   always_ff @(posedge clk) begin
      if (reset && writeM && ramSel) begin
         ramMem[addr[RAM_AW-1:0]] <= outM;
      end
   end

`ifdef HACK_MEM_SCREEN_EN
   logic [15:0] scrMem [8192];
   logic [15:0] scrData_q;

   // Screen buffer write port, same no-reset policy as the RAM.
   always_ff @(posedge clk) begin
      if (reset && writeM && scrSel) begin
         scrMem[addr[12:0]] <= outM;
      end
   end

   // Scan port reads the array as it was before this edge, so a CPU write
   // to the same word on the same edge shows up one cycle later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scrData_q <= '0;
      end else begin
         scrData_q <= scrMem[scr_addr];
      end
   end

   assign scrRead  = scrMem[addr[12:0]];
   assign scr_data = scrData_q;
`else
   logic unusedScan;

   // No screen storage in this build: the window reads 0 and the scan port
   // is tied off.
   assign scrRead    = '0;
   assign scr_data   = '0;
   assign unusedScan = ^{scr_addr, scrSel};
`endif

   // The FIFO accepts while not full. A pop only happens when something is
   // queued, so a pop strobe on an empty FIFO leaves the pointers alone.
   assign key_ready = (count_q < 5'(KBD_DEPTH));
   assign kbd_count = count_q;
   assign push      = key_valid && key_ready;
   assign pop       = writeM && kbdSel && (count_q != 5'd0);
   assign kbdHead   = (count_q != 5'd0) ? kbdMem[rdPtr_q] : 16'h0000;

   // Next-state for pointers and occupancy. Depth is a power of two, so the
   // pointers wrap for free at their natural width.
   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q + {4'd0, push} - {4'd0, pop};
      if (push) begin
         wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + PTR_W'(1);
      end
   end

   // FIFO control state; reset drops everything queued at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
      end
   end

   // FIFO storage needs no reset; stale words are unreachable once the
   // count is cleared.
   always_ff @(posedge clk) begin
      if (reset && push) begin
         kbdMem[wrPtr_q] <= key_code;
      end
   end

   // Zero-latency CPU read mux; anything unmapped falls through to 0.
   always_comb begin
      inM = 16'h0000;
      if (ramSel) begin
         inM = ramMem[addr[RAM_AW-1:0]];
      end else if (scrSel) begin
         inM = scrRead;
      end else if (kbdSel) begin
         inM = kbdHead;
      end
   end

endmodule

// File: tb/tb_hack_data_memory.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// TbHackDataMemory: self-checking bench for hack_data_memory.
// Directed table of write/read-back vectors, hand-written keyboard, screen
// and reset sequences, then randomized traffic compared against a simple
// map/queue model of the memory.
// ----------------------------------------------------------------------------
module tb_hack_data_memory;

   localparam int DEPTH = 4;
`ifdef HACK_MEM_SCREEN_EN
   localparam bit SCR_ON = 1'b1;
`else
   localparam bit SCR_ON = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [15:0] addrM;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] inM;
   logic [15:0] key_code;
   logic        key_valid;
   logic        key_ready;
   logic [4:0]  kbd_count;
   logic [12:0] scr_addr;
   logic [15:0] scr_data;

   int checks = 0;
   int errors = 0;

   // Reference model: sparse maps of written words, a queue for the FIFO.
   logic [15:0] ramModel [int];
   logic [15:0] scrModel [int];
   logic [15:0] fifoModel [$];
   logic [15:0] expScr;
   bit          expScrKnown;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] expData;
   } vec_t;

   vec_t        vecs [7];
   logic [15:0] drainExp [3];

   hack_data_memory #(.KBD_DEPTH(DEPTH), .RAM_WORDS(16384)) dut (
      .clk       (clk),
      .reset     (reset),
      .addrM     (addrM),
      .outM      (outM),
      .writeM    (writeM),
      .inM       (inM),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .kbd_count (kbd_count),
      .scr_addr  (scr_addr),
      .scr_data  (scr_data)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h required 0x%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic we,
                                input logic kv, input logic [15:0] kc);
      addrM     = a;
      outM      = d;
      writeM    = we;
      key_valid = kv;
      key_code  = kc;
   endtask

   task automatic modelReset();
      fifoModel.delete();
      expScr      = 16'h0000;
      expScrKnown = 1'b1;
   endtask

   // Applies the effect of one rising edge using the inputs currently held.
   task automatic modelEdge();
      int a;
      bit doPush;
      bit doPop;
      if (!reset) return;
      a      = int'(addrM[14:0]);
      doPush = key_valid && (fifoModel.size() < DEPTH);
      doPop  = writeM && (a == 'h6000) && (fifoModel.size() > 0);
      if (SCR_ON) begin
         if (scrModel.exists(int'(scr_addr))) begin
            expScr      = scrModel[int'(scr_addr)];
            expScrKnown = 1'b1;
         end else begin
            expScrKnown = 1'b0;
         end
      end else begin
         expScr      = 16'h0000;
         expScrKnown = 1'b1;
      end
      if (writeM) begin
         if (a < 'h4000) ramModel[a] = outM;
         else if (a < 'h6000 && SCR_ON) scrModel[a - 'h4000] = outM;
      end
      if (doPop) void'(fifoModel.pop_front());
      if (doPush) fifoModel.push_back(key_code);
   endtask

   task automatic cycle();
      modelEdge();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expectedInM(output logic [15:0] v, output bit known);
      int a;
      a     = int'(addrM[14:0]);
      v     = 16'h0000;
      known = 1'b1;
      if (a < 'h4000) begin
         if (ramModel.exists(a)) v = ramModel[a];
         else known = 1'b0;
      end else if (a < 'h6000) begin
         if (SCR_ON) begin
            if (scrModel.exists(a - 'h4000)) v = scrModel[a - 'h4000];
            else known = 1'b0;
         end
      end else if (a == 'h6000) begin
         if (fifoModel.size() > 0) v = fifoModel[0];
      end
   endtask

   task automatic checkAll(input string tag);
      logic [15:0] v;
      bit known;
      expectedInM(v, known);
      if (known) checkOutput({tag, " inM"}, inM, v);
      checkOutput({tag, " key_ready"}, {15'd0, key_ready}, {15'd0, fifoModel.size() < DEPTH});
      checkOutput({tag, " kbd_count"}, {11'd0, kbd_count}, 16'(fifoModel.size()));
      if (expScrKnown) checkOutput({tag, " scr_data"}, scr_data, expScr);
   endtask

   initial begin
      vecs[0] = '{16'h0010, 16'h1234, 16'h1234};
      vecs[1] = '{16'h3FFF, 16'hA5A5, 16'hA5A5};
      vecs[2] = '{16'h4000, 16'h5A5A, SCR_ON ? 16'h5A5A : 16'h0000};
      vecs[3] = '{16'h5FFF, 16'hC3C3, SCR_ON ? 16'hC3C3 : 16'h0000};
      vecs[4] = '{16'h6001, 16'h1111, 16'h0000};
      vecs[5] = '{16'h7000, 16'hBEEF, 16'h0000};
      vecs[6] = '{16'h7FFF, 16'h2222, 16'h0000};
      drainExp[0] = 16'h0053;
      drainExp[1] = 16'h0054;
      drainExp[2] = 16'h0056;

      // Reset state, entered asynchronously before any clock edge.
      reset    = 1'b1;
      scr_addr = 13'd0;
      applyStimulus(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      #1 reset = 1'b0;
      modelReset();
      #1;
      checkOutput("reset kbd_count", {11'd0, kbd_count}, 16'h0000);
      checkOutput("reset key_ready", {15'd0, key_ready}, 16'h0001);
      checkOutput("reset scr_data", scr_data, 16'h0000);
      checkOutput("reset kbd read", inM, 16'h0000);
      @(negedge clk);
      reset = 1'b1;

      // Table: write each address, read it back next cycle.
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].data, 1'b1, 1'b0, 16'h0000);
         cycle();
         writeM = 1'b0;
         #1 checkOutput($sformatf("vec%0d readback", i), inM, vecs[i].expData);
      end

      // RAM/screen boundary.
      addrM = 16'h3FFF;
      #1 checkOutput("boundary 0x3FFF", inM, 16'hA5A5);
      addrM = 16'h4000;
      #1 checkOutput("boundary 0x4000", inM, SCR_ON ? 16'h5A5A : 16'h0000);

      // RAM survives reset; writes during reset are dropped.
      applyStimulus(16'h0020, 16'h1111, 1'b1, 1'b0, 16'h0000);
      cycle();
      applyStimulus(16'h0020, 16'h2222, 1'b1, 1'b0, 16'h0000);
      #2 reset = 1'b0;
      modelReset();
      cycle();
      reset  = 1'b1;
      writeM = 1'b0;
      addrM  = 16'h0010;
      #1 checkOutput("ram after reset 0x0010", inM, 16'h1234);
      addrM = 16'h0020;
      #1 checkOutput("write blocked in reset", inM, 16'h1111);

      // Two keys in, pop them out in order, pop on empty is harmless.
      applyStimulus(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0041);
      cycle();
      key_code = 16'h0042;
      cycle();
      key_valid = 1'b0;
      #1 checkOutput("kbd head first", inM, 16'h0041);
      checkOutput("kbd count two", {11'd0, kbd_count}, 16'h0002);
      writeM = 1'b1;
      cycle();
      writeM = 1'b0;
      #1 checkOutput("kbd head second", inM, 16'h0042);
      writeM = 1'b1;
      cycle();
      writeM = 1'b0;
      #1 checkOutput("kbd empty read", inM, 16'h0000);
      checkOutput("kbd empty count", {11'd0, kbd_count}, 16'h0000);
      writeM = 1'b1;
      cycle();
      writeM = 1'b0;
      #1 checkOutput("pop on empty count", {11'd0, kbd_count}, 16'h0000);

      // Fill to depth with key_valid held, fifth key refused.
      applyStimulus(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0051);
      for (int i = 0; i < 4; i++) begin
         key_code = 16'(16'h0051 + i);
         cycle();
      end
      #1 checkOutput("full count", {11'd0, kbd_count}, 16'h0004);
      checkOutput("full key_ready", {15'd0, key_ready}, 16'h0000);
      key_code = 16'h0055;
      cycle();
      #1 checkOutput("fifth refused count", {11'd0, kbd_count}, 16'h0004);
      checkOutput("fifth refused head", inM, 16'h0051);
      // Pop while full: the push is refused because key_ready was low.
      writeM = 1'b1;
      cycle();
      writeM    = 1'b0;
      key_valid = 1'b0;
      #1 checkOutput("pop at full count", {11'd0, kbd_count}, 16'h0003);
      checkOutput("pop at full head", inM, 16'h0052);
      // Pop and push on the same edge keep the count.
      applyStimulus(16'h6000, 16'h0000, 1'b1, 1'b1, 16'h0056);
      cycle();
      writeM    = 1'b0;
      key_valid = 1'b0;
      #1 checkOutput("pop+push count", {11'd0, kbd_count}, 16'h0003);
      for (int i = 0; i < 3; i++) begin
         #1 checkOutput($sformatf("drain%0d head", i), inM, drainExp[i]);
         writeM = 1'b1;
         cycle();
         writeM = 1'b0;
      end
      #1 checkOutput("drained read", inM, 16'h0000);

      // Screen scan port latency and same-edge old value.
      applyStimulus(16'h4005, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
      scr_addr = 13'h0005;
      cycle();
      writeM = 1'b0;
      cycle();
      #1 checkOutput("scan after write", scr_data, SCR_ON ? 16'hFFFF : 16'h0000);
      applyStimulus(16'h4005, 16'h1234, 1'b1, 1'b0, 16'h0000);
      cycle();
      writeM = 1'b0;
      #1 checkOutput("scan same-edge old", scr_data, SCR_ON ? 16'hFFFF : 16'h0000);
      cycle();
      #1 checkOutput("scan new value", scr_data, SCR_ON ? 16'h1234 : 16'h0000);
      checkOutput("cpu read 0x4005", inM, SCR_ON ? 16'h1234 : 16'h0000);

      // Reset with three keys queued clears the FIFO without a clock.
      applyStimulus(16'h6000, 16'h0000, 1'b0, 1'b1, 16'h0061);
      for (int i = 0; i < 3; i++) begin
         key_code = 16'(16'h0061 + i);
         cycle();
      end
      key_valid = 1'b0;
      #1 checkOutput("three queued", {11'd0, kbd_count}, 16'h0003);
      #1 reset = 1'b0;
      modelReset();
      #1;
      checkOutput("async clr count", {11'd0, kbd_count}, 16'h0000);
      checkOutput("async clr ready", {15'd0, key_ready}, 16'h0001);
      checkOutput("async clr read", inM, 16'h0000);
      checkOutput("async clr scan", scr_data, 16'h0000);
      cycle();
      reset = 1'b1;
      #1 checkOutput("after release read", inM, 16'h0000);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [15:0] a;
         case ($urandom_range(0, 5))
            0:       a = 16'(16'h0000 + $urandom_range(0, 15));
            1:       a = 16'(16'h3FF8 + $urandom_range(0, 7));
            2:       a = 16'(16'h4000 + $urandom_range(0, 15));
            3:       a = 16'(16'h5FF8 + $urandom_range(0, 7));
            4:       a = 16'h6000;
            default: a = 16'(16'h6001 + $urandom_range(0, 16'h1FFE));
         endcase
         a[15] = 1'($urandom_range(0, 1));
         applyStimulus(a, 16'($urandom), ($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 1)), 16'($urandom));
         scr_addr = 13'($urandom_range(0, 15));
         #1 checkAll("rand");
         cycle();
      end
      applyStimulus(16'h6000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      #1 checkAll("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
